// File: rtl/pstats_event_gen.sv
// rtl/pstats_event_gen.sv - per-lane LFSR event-strobe generator with optional periodic all-lanes burst
module pstats_event_gen #(
  parameter int          g_trig_width   = 38,
  parameter logic [15:0] g_seed         = 16'h1D2C,
  parameter int          g_density      = 32,
  parameter int          g_burst_period = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  output logic [g_trig_width-1:0] trig_o
);

  // Burst counter is kept at least one bit wide so a disabled or period-1 burst still elaborates.
  localparam int          BC_W    = (g_burst_period > 1) ? $clog2(g_burst_period) : 1;
  localparam logic [BC_W-1:0] BC_LAST = (g_burst_period > 1) ? BC_W'(g_burst_period - 1) : '0;
  // Threshold is 9 bits so that 256 means "every byte value fires".
  localparam logic [8:0]  DENSITY = 9'(g_density);
  localparam logic        BURST_EN = (g_burst_period != 0);

  // Decorrelate lanes by mixing the lane index into the base seed; zero would lock the LFSR.
  function automatic logic [15:0] lane_seed(input int idx);
    logic [31:0] prod;
    logic [15:0] mixed;
    prod  = idx * 32'h0000_9E37;
    mixed = g_seed ^ prod[15:0];
    return (mixed == 16'h0000) ? 16'hACE1 : mixed;
  endfunction

  logic [15:0]             s_q [g_trig_width];
  logic [15:0]             s_d [g_trig_width];
  logic [g_trig_width-1:0] fire;
  logic [g_trig_width-1:0] trig_q;
  logic [g_trig_width-1:0] trig_d;
  logic [BC_W-1:0]         bc_q;
  logic [BC_W-1:0]         bc_d;
  logic                    burst;

  // Step every lane's Fibonacci LFSR (x^16+x^14+x^13+x^11+1) and threshold its new low byte.
  always_comb begin
    fire = '0;
    for (int i = 0; i < g_trig_width; i++) begin
      s_d[i]  = {s_q[i][14:0], s_q[i][15] ^ s_q[i][13] ^ s_q[i][12] ^ s_q[i][10]};
      fire[i] = ({1'b0, s_d[i][7:0]} < DENSITY);
    end
  end

  // Burst fires on the last count of the period; the counter wraps there and stays idle when disabled.
  always_comb begin
    burst = BURST_EN && (bc_q == BC_LAST);
    bc_d  = bc_q;
    if (!BURST_EN || (bc_q == BC_LAST)) begin
      bc_d = '0;
    end else begin
      bc_d = bc_q + 1'b1;
    end
    trig_d = fire | {g_trig_width{burst}};
  end

  // State registers: reset reloads the seeds so the sequence restarts identically after any reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_trig_width; i++) begin
        s_q[i] <= lane_seed(i);
      end
      bc_q   <= '0;
      trig_q <= '0;
    end else begin
      for (int i = 0; i < g_trig_width; i++) begin
        s_q[i] <= s_d[i];
      end
      bc_q   <= bc_d;
      trig_q <= trig_d;
    end
  end

  assign trig_o = trig_q;

endmodule

// File: tb/tb_pstats_event_gen.sv
// tb/tb_pstats_event_gen.sv - directed/table-driven bench for pstats_event_gen
module tb_pstats_event_gen;

  localparam int W    = 38;
  localparam int WB   = 304;
  localparam int NCYC = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  trig_main, trig_twin, trig_zero, trig_full, trig_p1;
  logic [WB-1:0] trig_burst;

  pstats_event_gen #(.g_trig_width(W), .g_seed(16'h1D2C), .g_density(32), .g_burst_period(0))
    u_main (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_main));
  pstats_event_gen #(.g_trig_width(W), .g_seed(16'h1D2C), .g_density(32), .g_burst_period(0))
    u_twin (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_twin));
  pstats_event_gen #(.g_trig_width(W), .g_density(0), .g_burst_period(0))
    u_zero (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_zero));
  pstats_event_gen #(.g_trig_width(W), .g_density(256), .g_burst_period(0))
    u_full (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_full));
  pstats_event_gen #(.g_trig_width(W), .g_density(0), .g_burst_period(1))
    u_p1 (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_p1));
  pstats_event_gen #(.g_trig_width(WB), .g_density(0), .g_burst_period(10))
    u_burst (.clk_i(clk), .rst_n_i(rst_n), .trig_o(trig_burst));

  typedef struct {
    int   edge_n;
    logic burst;
  } bvec_t;

  bvec_t bt[14];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]  ms [W];
  logic [W-1:0] first_hist [100];
  int           hi_cnt [W];
  logic [W-2:0] adj_diff;
  logic [W-1:0] model_trig;
  logic [WB-1:0] ones_b;
  logic [W-1:0]  ones_w;

  task automatic check(input string name, input int cyc, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] model_seed(input int i);
    logic [31:0] m;
    logic [15:0] s;
    m = 32'(i) * 32'd40503;
    s = 16'h1D2C ^ m[15:0];
    if (s == 16'd0) s = 16'hACE1;
    return s;
  endfunction

  // Taps 15,13,12,10 expressed as a parity mask.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < W; i++) ms[i] = model_seed(i);
  endtask

  task automatic model_advance();
    for (int i = 0; i < W; i++) begin
      ms[i] = model_step(ms[i]);
      model_trig[i] = (ms[i][7:0] < 8'd32);
    end
  endtask

  task automatic check_all_zero(input string name, input int cyc);
    check({name, "_main"},  cyc, WB'(trig_main),  '0);
    check({name, "_twin"},  cyc, WB'(trig_twin),  '0);
    check({name, "_zero"},  cyc, WB'(trig_zero),  '0);
    check({name, "_full"},  cyc, WB'(trig_full),  '0);
    check({name, "_p1"},    cyc, WB'(trig_p1),    '0);
    check({name, "_burst"}, cyc, trig_burst,      '0);
  endtask

  initial begin
    int bi;
    ones_b = '1;
    ones_w = '1;
    bt[0]  = '{1, 1'b0};   bt[1]  = '{2, 1'b0};   bt[2]  = '{9, 1'b0};
    bt[3]  = '{10, 1'b1};  bt[4]  = '{11, 1'b0};  bt[5]  = '{19, 1'b0};
    bt[6]  = '{20, 1'b1};  bt[7]  = '{21, 1'b0};  bt[8]  = '{30, 1'b1};
    bt[9]  = '{99, 1'b0};  bt[10] = '{100, 1'b1}; bt[11] = '{101, 1'b0};
    bt[12] = '{65530, 1'b1}; bt[13] = '{65531, 1'b0};

    for (int i = 0; i < W; i++) hi_cnt[i] = 0;
    adj_diff = '0;
    model_reset();

    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all_zero("reset_hold", c);
    end
    rst_n = 1'b1;

    bi = 0;
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      #1;
      model_advance();
      check("main_vs_model", k, WB'(trig_main), WB'(model_trig));
      check("twin_vs_model", k, WB'(trig_twin), WB'(model_trig));
      check("density0", k, WB'(trig_zero), '0);
      check("density256", k, WB'(trig_full), WB'(ones_w));
      check("period1", k, WB'(trig_p1), WB'(ones_w));
      check("burst_p10", k, trig_burst, (k % 10 == 0) ? ones_b : '0);
      if (bi < 14 && bt[bi].edge_n == k) begin
        check("burst_tbl", k, trig_burst, bt[bi].burst ? ones_b : '0);
        bi++;
      end
      if (k <= 100) first_hist[k-1] = trig_main;
      for (int i = 0; i < W; i++) hi_cnt[i] += int'(trig_main[i]);
      for (int i = 0; i < W - 1; i++) if (trig_main[i] != trig_main[i+1]) adj_diff[i] = 1'b1;
    end
    check("burst_tbl_all_hit", NCYC, WB'(bi), WB'(14));

    // Over one full LFSR period each low-byte value < 32 occurs 256 times except zero (255).
    for (int i = 0; i < W; i++) check($sformatf("lane%0d_rate", i), NCYC, WB'(hi_cnt[i]), WB'(8191));
    check("adjacent_lanes_differ", NCYC, WB'(adj_diff), WB'({(W-1){1'b1}}));

    // Mid-run reset, asserted away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_async", NCYC);
    @(negedge clk);
    check_all_zero("mid_reset_hold", NCYC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      model_advance();
      check("restart_vs_first", k, WB'(trig_main), WB'(first_hist[k-1]));
      check("restart_vs_model", k, WB'(trig_main), WB'(model_trig));
      check("restart_burst", k, trig_burst, (k % 10 == 0) ? ones_b : '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
